io_result_tx: RTL

//  Output-direction IO controller of the DCNN accelerator; mirror of the inbound load/DMA/decompress path.

---
 rtl/io_result_tx_if.sv | 18 +
 rtl/io_result_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/io_result_tx_if.sv
// Outbound score stream between the result controller and the host.
//
// Handshake: a word moves on every rising clk edge where io_valid and
// io_ready are both high. The master raises io_valid without waiting for
// io_ready. While io_valid is high and io_ready is low, the master holds
// io_data and io_last stable. io_valid stays high until that transfer has
// happened. io_last marks the final word of a frame.
interface io_result_tx_if #(
  parameter int DATA_W = 16
) ();
  logic              io_valid;
  logic              io_ready;
  logic [DATA_W-1:0] io_data;
  logic              io_last;

  modport master (output io_valid, output io_data, output io_last, input io_ready);
  modport slave  (input io_valid, input io_data, input io_last, output io_ready);
endinterface

// File: rtl/io_result_tx.sv
// Result transmit controller: buffers the classifier scores, tracks the argmax,
// interrupts the host, then streams the scores out and pulses done.
module io_result_tx #(
  parameter int NUM_WORDS = 10,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = $clog2(NUM_WORDS),
  parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_wr_en,
  input  logic [DATA_W-1:0] res_wr_data,
  input  logic              cnn_done,
  input  logic              host_ack,
  io_result_tx_if.master    io,
  output logic              interrupt,
  output logic [IDX_W-1:0]  class_idx,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NOTIFY = 2'd1,
    S_SEND   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0]  rd_ptr, rd_ptr_n;
  logic [DATA_W-1:0] max_q, max_n;
  logic [IDX_W-1:0]  class_idx_n;
  logic              overflow_n, interrupt_n, busy_n, done_n;
  logic              io_valid_q, io_valid_n;
  logic [DATA_W-1:0] io_data_q, io_data_n;
  logic              io_last_q, io_last_n;
  logic              mem_we;
  logic [DATA_W-1:0] score_mem [NUM_WORDS];

  assign io.io_valid = io_valid_q;
  assign io.io_data  = io_data_q;
  assign io.io_last  = io_last_q;
  assign state_dbg   = state;

  // Score buffer write port; only accepted writes in IDLE reach it.
  always_ff @(posedge clk) begin
    if (mem_we) score_mem[wr_ptr[IDX_W-1:0]] <= res_wr_data;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    max_n       = max_q;
    class_idx_n = class_idx;
    overflow_n  = overflow;
    interrupt_n = interrupt;
    io_valid_n  = io_valid_q;
    io_data_n   = io_data_q;
    io_last_n   = io_last_q;
    done_n      = 1'b0;
    mem_we      = 1'b0;

    case (state)
      S_IDLE: begin
        if (res_wr_en) begin
          if (wr_ptr < CNT_W'(NUM_WORDS)) begin
            mem_we   = 1'b1;
            wr_ptr_n = wr_ptr + CNT_W'(1);
            if (wr_ptr == '0) begin
              // First word of a frame: restart the argmax and clear the sticky flag.
              max_n       = res_wr_data;
              class_idx_n = '0;
              overflow_n  = 1'b0;
            end else if ($signed(res_wr_data) > $signed(max_q)) begin
              // Strictly greater only, so ties keep the lowest index.
              max_n       = res_wr_data;
              class_idx_n = wr_ptr[IDX_W-1:0];
            end
          end else begin
            overflow_n = 1'b1;
          end
        end
        // An empty frame is ignored; a write in the same cycle makes it non-empty.
        if (cnn_done && (wr_ptr != '0 || res_wr_en)) begin
          state_n     = S_NOTIFY;
          interrupt_n = 1'b1;
        end
      end

      S_NOTIFY: begin
        if (res_wr_en) overflow_n = 1'b1;
        if (host_ack) begin
          state_n     = S_SEND;
          interrupt_n = 1'b0;
          io_valid_n  = 1'b1;
          io_data_n   = score_mem[0];
          io_last_n   = (wr_ptr == CNT_W'(1));
        end
      end

      S_SEND: begin
        if (res_wr_en) overflow_n = 1'b1;
        if (io_valid_q && io.io_ready) begin
          if (io_last_q) begin
            io_valid_n = 1'b0;
            state_n    = S_FINISH;
            done_n     = 1'b1;
          end else begin
            rd_ptr_n  = rd_ptr + CNT_W'(1);
            io_data_n = score_mem[rd_ptr_n[IDX_W-1:0]];
            io_last_n = (rd_ptr_n == wr_ptr - CNT_W'(1));
          end
        end
      end

      S_FINISH: begin
        if (res_wr_en) overflow_n = 1'b1;
        state_n  = S_IDLE;
        wr_ptr_n = '0;
        rd_ptr_n = '0;
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      max_q      <= '0;
      class_idx  <= '0;
      overflow   <= 1'b0;
      interrupt  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      io_valid_q <= 1'b0;
      io_data_q  <= '0;
      io_last_q  <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      max_q      <= max_n;
      class_idx  <= class_idx_n;
      overflow   <= overflow_n;
      interrupt  <= interrupt_n;
      busy       <= busy_n;
      done       <= done_n;
      io_valid_q <= io_valid_n;
      io_data_q  <= io_data_n;
      io_last_q  <= io_last_n;
    end
  end

endmodule
